// File: rtl/traffic_control_param_pkg.sv
//------------------------------------------------------------------------------
// Module   : traffic_pkg
// Brief    : State codes, lamp codes and phase-duration helper for the
//            parametrised two-approach traffic controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package traffic_pkg;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6,
        S7 = 3'd7
    } state_t;

    localparam logic [2:0] LAMP_GREEN        = 3'b110;
    localparam logic [2:0] LAMP_G_LEFT       = 3'b101;
    localparam logic [2:0] LAMP_YELLOW       = 3'b100;
    localparam logic [2:0] LAMP_RED          = 3'b011;
    localparam logic [2:0] LAMP_G_RIGHT      = 3'b010;
    localparam logic [2:0] LAMP_FLASH_RED    = 3'b111;
    localparam logic [2:0] LAMP_FLASH_YELLOW = 3'b000;

    // S7 is untimed; it reports one cycle so the timer simply loads zero.
    function automatic int unsigned phase_cycles(
        input state_t      s,
        input int unsigned t_green,
        input int unsigned t_left,
        input int unsigned t_yellow,
        input int unsigned t_ped
    );
        case (s)
            S0:      return t_ped;
            S1, S4:  return t_green;
            S2, S5:  return t_left;
            S3, S6:  return t_yellow;
            default: return 32'd1;
        endcase
    endfunction

    function automatic logic [2:0] lamp_a(input state_t s);
        case (s)
            S0:      return LAMP_FLASH_RED;
            S1:      return LAMP_GREEN;
            S2:      return LAMP_G_LEFT;
            S3:      return LAMP_YELLOW;
            S4:      return LAMP_RED;
            S5, S6:  return LAMP_G_RIGHT;
            default: return LAMP_FLASH_YELLOW;
        endcase
    endfunction

    function automatic logic [2:0] lamp_b(input state_t s);
        case (s)
            S0:      return LAMP_FLASH_RED;
            S1:      return LAMP_RED;
            S2, S3:  return LAMP_G_RIGHT;
            S4:      return LAMP_GREEN;
            S5:      return LAMP_G_LEFT;
            S6:      return LAMP_YELLOW;
            default: return LAMP_FLASH_YELLOW;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_control_param_if.sv
//------------------------------------------------------------------------------
// Module   : traffic_control_param_if
// Brief    : Request inputs and lamp/status outputs of the traffic controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface traffic_control_param_if;
    logic       ERR;
    logic       NIGHT;
    logic       PA;
    logic       PB;
    logic       LTA;
    logic       LTB;
    logic [2:0] L_A;
    logic [2:0] L_B;
    logic       RA;
    logic       RB;
    logic       PA_PEND;
    logic       PB_PEND;
    logic [2:0] STATE;

    modport master (
        output ERR, NIGHT, PA, PB, LTA, LTB,
        input  L_A, L_B, RA, RB, PA_PEND, PB_PEND, STATE
    );

    modport slave (
        input  ERR, NIGHT, PA, PB, LTA, LTB,
        output L_A, L_B, RA, RB, PA_PEND, PB_PEND, STATE
    );
endinterface

`default_nettype wire

// File: rtl/traffic_phase_timer.sv
//------------------------------------------------------------------------------
// Module   : traffic_phase_timer
// Brief    : Loadable down-counter flagging the last cycle of a phase.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module traffic_phase_timer #(
    parameter int TW = 4
) (
    input  wire logic          CLK,
    input  wire logic          reset,
    input  wire logic          load,
    input  wire logic [TW-1:0] load_val,
    output logic               done
);

    logic [TW-1:0] r_count;

    assign done = (r_count == '0);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (!done) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/traffic_control_param.sv
//------------------------------------------------------------------------------
// Module   : traffic_control_param
// Brief    : Two-approach Moore traffic controller with timed phases, optional
//            left-turn skipping, night flash and pedestrian-pending status.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module traffic_control_param
    import traffic_pkg::*;
#(
    parameter int unsigned T_GREEN    = 8,
    parameter int unsigned T_LEFT     = 3,
    parameter int unsigned T_YELLOW   = 3,
    parameter int unsigned T_PED      = 6,
    parameter bit          LT_SKIP_EN = 1'b0
) (
    input wire logic                CLK,
    input wire logic                reset,
    traffic_control_param_if.slave  bus
);

    localparam int unsigned c_T_GL  = (T_GREEN  > T_LEFT) ? T_GREEN  : T_LEFT;
    localparam int unsigned c_T_YP  = (T_YELLOW > T_PED)  ? T_YELLOW : T_PED;
    localparam int unsigned c_T_MAX = (c_T_GL > c_T_YP)   ? c_T_GL   : c_T_YP;
    localparam int          TW      = $clog2(c_T_MAX) + 1;

    state_t        r_state;
    state_t        w_next;
    logic          w_enter;
    logic          w_done;
    logic [TW-1:0] w_load_val;
    logic          r_pa_pend;
    logic          r_pb_pend;
    logic          r_lta;
    logic          r_ltb;
    logic          r_from_s3;
    logic [2:0]    r_la;
    logic [2:0]    r_lb;
    logic          r_walk;

    always_comb begin
        w_next = r_state;
        if (bus.ERR) begin
            w_next = S7;
        end else if (r_state == S7) begin
            if (!bus.NIGHT) w_next = S0;
        end else if (w_done) begin
            case (r_state)
                S0:      w_next = r_from_s3 ? S4 : S1;
                S1:      w_next = (LT_SKIP_EN && !r_lta) ? S3 : S2;
                S2:      w_next = S3;
                S3:      w_next = bus.NIGHT ? S7 : (r_pa_pend ? S0 : S4);
                S4:      w_next = (LT_SKIP_EN && !r_ltb) ? S6 : S5;
                S5:      w_next = S6;
                S6:      w_next = bus.NIGHT ? S7 : (r_pb_pend ? S0 : S1);
                default: w_next = S7;
            endcase
        end
    end

    assign w_enter    = (w_next != r_state);
    assign w_load_val = TW'(phase_cycles(w_next, T_GREEN, T_LEFT, T_YELLOW, T_PED) - 32'd1);

    traffic_phase_timer #(
        .TW (TW)
    ) u_timer (
        .CLK      (CLK),
        .reset    (reset),
        .load     (w_enter),
        .load_val (w_load_val),
        .done     (w_done)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state   <= S7;
            r_pa_pend <= 1'b0;
            r_pb_pend <= 1'b0;
            r_lta     <= 1'b0;
            r_ltb     <= 1'b0;
            r_from_s3 <= 1'b0;
            r_la      <= LAMP_FLASH_YELLOW;
            r_lb      <= LAMP_FLASH_YELLOW;
            r_walk    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_la    <= lamp_a(w_next);
            r_lb    <= lamp_b(w_next);
            r_walk  <= (w_next == S0);

            // Both walks run together in S0, so entry serves both requests.
            if (w_enter && w_next == S0) begin
                r_pa_pend <= 1'b0;
                r_pb_pend <= 1'b0;
                r_from_s3 <= (r_state == S3);
            end else if (r_state != S0 && r_state != S7) begin
                if (bus.PA) r_pa_pend <= 1'b1;
                if (bus.PB) r_pb_pend <= 1'b1;
            end

            if (w_enter && (w_next == S2 || (r_state == S1 && w_next == S3))) begin
                r_lta <= 1'b0;
            end else if (bus.LTA && r_state != S2) begin
                r_lta <= 1'b1;
            end

            if (w_enter && (w_next == S5 || (r_state == S4 && w_next == S6))) begin
                r_ltb <= 1'b0;
            end else if (bus.LTB && r_state != S5) begin
                r_ltb <= 1'b1;
            end
        end
    end

    assign bus.L_A     = r_la;
    assign bus.L_B     = r_lb;
    assign bus.RA      = r_walk;
    assign bus.RB      = r_walk;
    assign bus.PA_PEND = r_pa_pend;
    assign bus.PB_PEND = r_pb_pend;
    assign bus.STATE   = r_state;

endmodule

`default_nettype wire

// File: doc/traffic_control_param.md
Name: traffic_control_param

Overview:
- Parametrised successor to the two-approach traffic-light controller (approaches A and B).
- Phase durations are set by parameters. Adds optional left-turn phase skipping, a night flash mode, and pedestrian-pending status outputs.
- Sits between the debounced/synchronised input front end (pedestrian buttons, loop sensors, fault monitor) and the lamp drivers.
- Moore FSM with an internal phase timer; all inputs other than reset are synchronous.

Parameters:
- T_GREEN, 8: cycles in S1/S4 (straight green). Must be ≥1.
- T_LEFT, 3: cycles in S2/S5 (protected left). Must be ≥1.
- T_YELLOW, 3: cycles in S3/S6 (yellow). Must be ≥1.
- T_PED, 6: cycles in S0 (all-red flash, pedestrian walk). Must be ≥1.
- LT_SKIP_EN, 0: 1 = skip S2/S5 when no left-turn demand is latched.
- TW, derived: timer width = clog2(max of all T_*) + 1.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces S7.
- ERR  in  1  sync fault request, active-high; highest synchronous priority.
- NIGHT  in  1  sync night-mode request.
- PA  in  1  sync pedestrian request, approach A.
- PB  in  1  sync pedestrian request, approach B.
- LTA  in  1  left-turn vehicle demand, approach A.
- LTB  in  1  left-turn vehicle demand, approach B.
- L_A  out  3  lamp code, approach A.
- L_B  out  3  lamp code, approach B.
- RA  out  1  pedestrian walk, approach A.
- RB  out  1  pedestrian walk, approach B.
- PA_PEND  out  1  PA request latched, not yet served.
- PB_PEND  out  1  PB request latched, not yet served.
- STATE  out  3  current state index (debug).

Behaviour:
- Lamp codes: GREEN 110, G_LEFT 101, YELLOW 100, RED 011, G_RIGHT 010, FLASH_RED 111, FLASH_YELLOW 000.
- States and (L_A, L_B):
  - S0 = (FLASH_RED, FLASH_RED)
  - S1 = (GREEN, RED)
  - S2 = (G_LEFT, G_RIGHT)
  - S3 = (YELLOW, G_RIGHT)
  - S4 = (RED, GREEN)
  - S5 = (G_RIGHT, G_LEFT)
  - S6 = (G_RIGHT, YELLOW)
  - S7 = (FLASH_YELLOW, FLASH_YELLOW)
- RA = RB = 1 only in S0; 0 in all other states.
- All outputs are decoded from registered state and pend flags. No input-to-output combinational path.
- Reset (asynchronous): state = S7, timer = 0, both pend flags = 0, both left-turn latches = 0. Outputs read L_A = L_B = 000, RA = RB = 0, PA_PEND = PB_PEND = 0, STATE = 7.
- Timer: loads T_x−1 on state entry and decrements each cycle. The state exits on the edge where the timer = 0, so every timed state lasts exactly T_x cycles.
- Next-state priority per edge:
  1. ERR = 1 → S7 from any state.
  2. In S7: stay while ERR or NIGHT is high; otherwise → S0 (timer loads T_PED).
  3. Otherwise the normal timed sequence applies.
- Normal sequence:
  - S0 → S4 if served from S3; → S1 in all other cases (including post-reset, post-ERR, post-NIGHT, and served from S6).
  - S1 → S2. If LT_SKIP_EN = 1 and the A left-turn latch = 0 → S3 instead.
  - S2 → S3.
  - S3 → S7 if NIGHT = 1; else → S0 if PA_PEND = 1; else → S4.
  - S4 → S5. If LT_SKIP_EN = 1 and the B left-turn latch = 0 → S6 instead.
  - S5 → S6.
  - S6 → S7 if NIGHT = 1; else → S0 if PB_PEND = 1; else → S1.
- Served-from tracking: a 1-bit register records whether S0 was entered from S3.
- Pedestrian latch:
  - PA/PB sampled high in any state other than S0/S7 sets the corresponding pend flag.
  - Entering S0 clears both flags, since both walks are active.
  - A press on the same edge as S0 entry is dropped.
  - PB pending at the end of S3 waits until the end of S6.
- Left-turn latch:
  - LTA is latched in any state except S2; the latch clears on S2 entry, or on S3 entry when S2 is skipped.
  - LTB is handled symmetrically with S5/S6.
- ERR or NIGHT asserted mid-phase:
  - ERR pre-empts on the next edge.
  - NIGHT takes effect only at the end of a yellow phase (S3/S6).
- Reset asserted mid-operation: immediate return to S7, all latches cleared.

Decomposition:
- Shared package traffic_pkg holds:
  - state codes S0–S7
  - lamp-code constants
  - a function returning a state's duration from the parameters.
- One sub-module, traffic_phase_timer (TW-bit load/decrement/done), with the same CLK and reset.

Test Plan:
1. Reset for 2 cycles, then release. Required sequence:
   - S7, then S0 for 6 cycles with RA = RB = 1
   - S1 for 8 cycles, S2 for 3, S3 for 3, S4 for 8, S5 for 3, S6 for 3, back to S1.
2. PA pulse for 1 cycle during S2:
   - PA_PEND = 1 on the next cycle.
   - After S3 (3 cycles): S0 for 6 cycles with RA = RB = 1 and PA_PEND = 0, then S4.
   - PA pulsed during S0 must not set PA_PEND.
3. PB pulse during S5, and ERR asserted for 10 cycles during S1:
   - Served through S0, then S1.
   - While ERR is high: S7 (000/000).
   - After ERR falls: S0 for 6 cycles, then S1.
4. NIGHT raised during S1:
   - S1 and S2 complete; S3 → S7, which holds while NIGHT is high.
   - After NIGHT falls: S0 for 6 cycles, then S1.
5. LT_SKIP_EN = 1, T_GREEN = 12, LTA never asserted, LTB pulsed during S1:
   - S1 lasts 12 cycles, then goes directly to S3.
   - S4 → S5 for 3 cycles.
6. Asynchronous reset pulse in the middle of S4, with PA_PEND = 1:
   - Outputs go to 000/000 and PA_PEND = 0 before the next clock edge.
   - Normal restart from S7 follows.
